// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding, byte-enable constants and defaults for mem_access_unit.
package mem_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    localparam logic [3:0] BE_WORD = 4'hF;
    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam int TIMEOUT_CYCLES_DEF = 16;
    localparam logic [31:0] ERR_RDATA_DEF = 32'h0000_0000;
endpackage

// File: rtl/byte_lane_unit.sv
// byte_lane_unit: byte-enable generation, store lane replication and load byte extraction.
module byte_lane_unit
    import mem_pkg::*;
(
    input  logic        ByteMem,
    input  logic [1:0]  Addr,
    input  logic [31:0] WriteData,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic [31:0] ReadData
);
    always_comb begin
        mem_be = ByteMem ? (BE_BYTE0 << Addr) : BE_WORD;
        mem_wdata = ByteMem ? {4{WriteData[7:0]}} : WriteData;
        ReadData = ByteMem ? {24'h0, mem_rdata[{Addr, 3'b000} +: 8]} : mem_rdata;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: req/ack data-memory access stage with core stall and byte-lane steering.
// Define MEM_TIMEOUT_EN to abort requests that see no ack within TIMEOUT_CYCLES.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        ByteMem,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        AccessErr
);
    state_t state;
    logic byte_q;
    logic [1:0] off_q;
    logic lane_byte;
    logic [1:0] lane_off;
    logic [3:0] lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
`else
    logic unused_cfg;
    assign unused_cfg = ^{ERR_RDATA, TIMEOUT_CYCLES};
    assign AccessErr = 1'b0;
`endif
    // Lanes follow the live request while launching, the latched one afterwards.
    assign lane_byte = (state == IDLE) ? ByteMem : byte_q;
    assign lane_off = (state == IDLE) ? Addr[1:0] : off_q;
    assign Stall = (state == REQ) | (state == IDLE & (MemWrite | MemtoReg));
    byte_lane_unit u_lanes (
        .ByteMem(lane_byte),
        .Addr(lane_off),
        .WriteData(WriteData),
        .mem_rdata(mem_rdata),
        .mem_be(lane_be),
        .mem_wdata(lane_wdata),
        .ReadData(lane_rdata)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_be <= 4'h0;
            mem_addr <= 32'h0;
            mem_wdata <= 32'h0;
            ReadData <= 32'h0;
            byte_q <= 1'b0;
            off_q <= 2'b00;
`ifdef MEM_TIMEOUT_EN
            cnt <= '0;
            AccessErr <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (MemWrite | MemtoReg) begin
                    state <= REQ;
                    mem_req <= 1'b1;
                    mem_we <= MemWrite;
                    mem_be <= lane_be;
                    mem_wdata <= lane_wdata;
                    mem_addr <= {Addr[31:2], 2'b00};
                    byte_q <= ByteMem;
                    off_q <= Addr[1:0];
`ifdef MEM_TIMEOUT_EN
                    cnt <= '0;
`endif
                end
                REQ: begin
                    if (mem_ack) begin
                        state <= DONE;
                        mem_req <= 1'b0;
                        if (!mem_we) ReadData <= lane_rdata;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        state <= DONE;
                        mem_req <= 1'b0;
                        AccessErr <= 1'b1;
                        if (!mem_we) ReadData <= ERR_RDATA;
                    end else cnt <= cnt + 1'b1;
`endif
                end
                DONE: begin
                    state <= IDLE;
`ifdef MEM_TIMEOUT_EN
                    AccessErr <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access stage directly downstream of the core controller.
- Consumes MemWrite, MemtoReg (read request) and ByteMem, plus the datapath's ALU address and write data.
- Runs a multi-cycle req/ack transaction to a word-wide data memory, with byte-lane steering for ldrb/strb.
- Stalls the core while a transaction is outstanding and returns ReadData for write-back.

Parameters:
- TIMEOUT_CYCLES, 16, cycles in REQ without ack before abort; used only with MEM_TIMEOUT_EN.
- ERR_RDATA, 32'h0000_0000, ReadData value returned on a timed-out load.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- MemWrite  in  1  store request from controller
- MemtoReg  in  1  load request from controller
- ByteMem  in  1  1 = byte access (ldrb/strb), 0 = word
- Addr  in  32  byte address (ALUResult)
- WriteData  in  32  store data (Rd value)
- ReadData  out  32  load result to the write-back mux
- Stall  out  1  core must hold PC and instruction while high
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_be  out  4  byte enables
- mem_addr  out  32  word-aligned address, bits [1:0] = 0
- mem_wdata  out  32  store data lanes
- mem_rdata  in  32  memory read data
- mem_ack  in  1  memory completion
- AccessErr  out  1  timeout pulse; tied 0 without MEM_TIMEOUT_EN

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE; mem_req, mem_we, Stall, AccessErr = 0; mem_be = 0; mem_addr, mem_wdata, ReadData = 0.
- State machine: IDLE -> REQ -> DONE -> IDLE.
- IDLE:
  - Request = MemWrite | MemtoReg.
  - Stall is combinationally 1 whenever a request is present.
  - At the clock edge, latch Addr, WriteData, ByteMem and direction, then go to REQ.
  - If MemWrite and MemtoReg are both high, the write wins (mem_we = 1).
- REQ:
  - mem_req = 1 and Stall = 1. mem_addr, mem_we, mem_be and mem_wdata come from registered values and are stable for the whole of REQ.
  - When mem_ack is sampled 1: capture mem_rdata, go to DONE, and drop mem_req at that edge.
- DONE:
  - Stall = 0 and ReadData is valid for exactly one cycle, so the core commits the instruction at the edge ending DONE.
  - Always returns to IDLE; a new instruction cannot re-launch from DONE.
- Latency: with zero-wait memory (ack in the first REQ cycle), an access spans 3 cycles with Stall high for 2. Each extra wait cycle adds 1.
- Byte access:
  - mem_be = 4'b0001 << Addr[1:0].
  - mem_wdata = WriteData[7:0] replicated in all 4 lanes.
  - Load: ReadData = zero-extended byte mem_rdata[8*Addr[1:0] +: 8].
- Word access: mem_be = 4'hF, mem_wdata = WriteData, ReadData = mem_rdata. Addr[1:0] is ignored.
- mem_ack sampled while not in REQ is ignored.
- ReadData holds its last value outside DONE. Stores leave ReadData unchanged.
- Reset mid-transaction: on the next edge go to IDLE with all outputs at reset values. mem_req falls even if no ack has arrived; the memory must tolerate an abandoned request.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro:
  - A cycle counter clears on entry to REQ and increments each REQ cycle.
  - If it reaches TIMEOUT_CYCLES with no ack: drop mem_req, go to DONE, set ReadData = ERR_RDATA (loads only), and pulse AccessErr = 1 for that DONE cycle.
  - An ack in the same cycle as the terminal count wins (normal completion).
- Without the macro: no counter, REQ waits for ack indefinitely, AccessErr is constant 0.

Decomposition:
- Package mem_pkg holds:
  - state enum {IDLE, REQ, DONE};
  - BE_WORD = 4'hF and BE_BYTE0 = 4'b0001;
  - default TIMEOUT_CYCLES and ERR_RDATA.
- One combinational sub-module, byte_lane_unit: inputs ByteMem, Addr[1:0], WriteData, mem_rdata; outputs mem_be, mem_wdata, ReadData.

Test Plan:
- Word store, Addr = 0x1000, WriteData = 0xCAFEBABE, ack in first REQ cycle -> mem_addr = 0x1000, mem_be = 0xF, mem_we = 1, mem_wdata = 0xCAFEBABE; Stall high 2 cycles, mem_req high 1 cycle.
- Byte load (ldrb), Addr = 0x2003, mem_rdata = 0x11223344, ack after 3 wait cycles -> mem_addr = 0x2000, mem_be = 0x8; ReadData = 0x00000011 in DONE; Stall high 5 cycles.
- Byte store (strb), Addr = 0x2001, WriteData = 0xFFFFFFA5 -> mem_be = 0x2, mem_wdata = 0xA5A5A5A5.
- Spurious mem_ack in IDLE with no request -> no state change, Stall = 0, ReadData unchanged; then MemWrite and MemtoReg both 1 -> mem_we = 1.
- reset asserted in the 2nd REQ cycle -> next edge: IDLE, mem_req = 0, Stall = 0, ReadData = 0; a later ack is ignored.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, word load with no ack -> after 4 REQ cycles: mem_req drops, DONE with ReadData = 0x00000000 and a one-cycle AccessErr pulse. Without the macro, the same stimulus keeps Stall high indefinitely.
